uart_rx_ctrl: RTL and testbench

Receive-side frame controller of the UART RX path. It detects the start bit, runs the per-bit oversampling edge counter and bit counter, and produces the majority-voted `sampled_bit`. It sequences the start, data, parity and stop phases and drives the enable strobes consumed by the deserializer and by the parity checker. At the end of each frame it reports a `data_valid` pulse or the error flags.

---
 rtl/uart_rx_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller with oversampling counters, 2-of-3 bit voting,
// deserializer/parity strobes and per-frame valid/error reporting.
module uart_rx_ctrl #(
  parameter int PRESC_W = 6,
  parameter int CNT_W   = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               par_err,
  output logic [CNT_W-1:0]   edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               sampled_bit,
  output logic               deser_en,
  output logic               par_chk_en,
  output logic               data_valid,
  output logic               stp_err,
  output logic               par_fail
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic [1:0] smp_q, smp_d;
  logic sampled_q, sampled_d;
  logic par_flag_q, par_flag_d, stp_flag_q, stp_flag_d;
  logic deser_q, deser_d, pchk_q, pchk_d;
  logic dv_q, dv_d, se_q, se_d, pf_q, pf_d;
  logic [PRESC_W-1:0] e, half;
  logic bit_end, at_chk;
  assign e       = PRESC_W'(edge_q);
  assign half    = Prescale >> 1;
  assign bit_end = e == Prescale - PRESC_W'(1);
  assign at_chk  = e == Prescale - PRESC_W'(2);
  always_comb begin
    state_d    = state_q;
    edge_d     = bit_end ? '0 : edge_q + CNT_W'(1);
    bit_d      = bit_end ? bit_q + 4'd1 : bit_q;
    smp_d      = smp_q;
    sampled_d  = sampled_q;
    par_flag_d = par_flag_q;
    stp_flag_d = stp_flag_q;
    dv_d       = 1'b0;
    se_d       = 1'b0;
    pf_d       = 1'b0;
    if (e == half - PRESC_W'(1)) smp_d[0] = RX_IN;
    if (e == half) smp_d[1] = RX_IN;
    if (e == half + PRESC_W'(1)) sampled_d = (smp_q[0] & smp_q[1]) | (smp_q[0] & RX_IN) | (smp_q[1] & RX_IN);
    case (state_q)
      IDLE: begin
        edge_d = RX_IN ? '0 : CNT_W'(1);
        bit_d  = '0;
        if (!RX_IN) begin
          state_d    = START;
          par_flag_d = 1'b0;
          stp_flag_d = 1'b0;
        end
      end
      START: begin
        if (at_chk && sampled_q) begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end else if (bit_end) state_d = DATA;
      end
      DATA: if (bit_end && bit_q == 4'd8) state_d = PAR_EN ? PARITY : STOP;
      PARITY: begin
        if (bit_end) begin
          par_flag_d = par_err;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (at_chk && !sampled_q) stp_flag_d = 1'b1;
        if (bit_end) begin
          state_d = IDLE;
          bit_d   = '0;
          dv_d    = !par_flag_q && !stp_flag_q;
          pf_d    = par_flag_q;
          se_d    = stp_flag_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // strobes are derived from next-state values so the registered outputs line up with edge_cnt
    deser_d = state_d == DATA && PRESC_W'(edge_d) == Prescale - PRESC_W'(2);
    pchk_d  = state_d == PARITY;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      smp_q      <= 2'b11;
      sampled_q  <= 1'b1;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
      deser_q    <= 1'b0;
      pchk_q     <= 1'b0;
      dv_q       <= 1'b0;
      se_q       <= 1'b0;
      pf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      smp_q      <= smp_d;
      sampled_q  <= sampled_d;
      par_flag_q <= par_flag_d;
      stp_flag_q <= stp_flag_d;
      deser_q    <= deser_d;
      pchk_q     <= pchk_d;
      dv_q       <= dv_d;
      se_q       <= se_d;
      pf_q       <= pf_d;
    end
  end
  assign edge_cnt    = edge_q;
  assign bit_cnt     = bit_q;
  assign sampled_bit = sampled_q;
  assign deser_en    = deser_q;
  assign par_chk_en  = pchk_q;
  assign data_valid  = dv_q;
  assign stp_err     = se_q;
  assign par_fail    = pf_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames against uart_rx_ctrl; a negedge monitor accumulates
// strobe/pulse counts and the deserialized byte, checked as deltas per frame.
module tb_uart_rx_ctrl;
  logic CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0, par_err = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic sampled_bit, deser_en, par_chk_en, data_valid, stp_err, par_fail;
  int n_cmp = 0, n_err = 0, cyc = 0, t0 = 0;
  int n_deser = 0, n_bad = 0, n_pchk9 = 0, n_pchko = 0, n_dv = 0, n_se = 0, n_pf = 0, dv_cyc = 0;
  int s_deser, s_bad, s_pchk9, s_pchko, s_dv, s_se, s_pf;
  logic [7:0] rx_byte = 8'h00;
  int ek [10];
  int sk [10];
  uart_rx_ctrl #(.PRESC_W(6), .CNT_W(5)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale), .par_err(par_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sampled_bit(sampled_bit), .deser_en(deser_en),
    .par_chk_en(par_chk_en), .data_valid(data_valid), .stp_err(stp_err), .par_fail(par_fail)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (deser_en) begin
      n_deser <= n_deser + 1;
      if (int'(edge_cnt) != int'(Prescale) - 2) n_bad <= n_bad + 1;
      rx_byte <= {sampled_bit, rx_byte[7:1]};
    end
    if (par_chk_en && bit_cnt == 4'd9) n_pchk9 <= n_pchk9 + 1;
    if (par_chk_en && bit_cnt != 4'd9) n_pchko <= n_pchko + 1;
    if (data_valid) begin
      n_dv <= n_dv + 1;
      dv_cyc <= cyc;
    end
    if (stp_err) n_se <= n_se + 1;
    if (par_fail) n_pf <= n_pf + 1;
  end
  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic snap();
    s_deser = n_deser; s_bad = n_bad; s_pchk9 = n_pchk9; s_pchko = n_pchko;
    s_dv = n_dv; s_se = n_se; s_pf = n_pf;
  endtask
  // Cycle j of bit i shows edge_cnt j / bit_cnt i, so flips and par_err land on exact counter values.
  task automatic send(input int p, input logic [7:0] d, input bit pe, input bit stop, input bit perr,
                      input int flip_bit, input int rst_bit);
    logic [10:0] b;
    int nb;
    Prescale = 6'(p);
    PAR_EN = pe;
    b = pe ? {stop, ^d, d, 1'b0} : {1'b1, stop, d, 1'b0};
    nb = pe ? 11 : 10;
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < p; j++) begin
        @(posedge CLK); #1;
        if (i == rst_bit && j == 3) begin
          RST = 1'b0;
          RX_IN = 1'b1;
          return;
        end
        RX_IN = b[i] ^ (i == flip_bit && j == 4);
        par_err = perr && pe && i == 9 && j == p - 1;
        if (i == 0 && j == 0) t0 = cyc;
      end
    @(posedge CLK); #1;
    RX_IN = 1'b1;
    par_err = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_edge", edge_cnt, 0);
    check("rst_bit", bit_cnt, 0);
    check("rst_sampled", sampled_bit, 1);
    check("rst_strobes", {deser_en, par_chk_en, data_valid, stp_err, par_fail}, 0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    // P=8 no parity: 10 bits of 8 cycles, pulse in the cycle right after the frame
    snap();
    send(8, 8'hA5, 0, 1, 0, -1, -1);
    check("a5_deser", n_deser - s_deser, 8);
    check("a5_deser_edge", n_bad - s_bad, 0);
    check("a5_byte", rx_byte, 8'hA5);
    check("a5_dv", n_dv - s_dv, 1);
    check("a5_latency", dv_cyc - t0, 80);
    check("a5_errs", (n_se - s_se) + (n_pf - s_pf), 0);
    snap();
    send(16, 8'h3C, 1, 1, 0, -1, -1);
    check("3c_pchk9", n_pchk9 - s_pchk9, 16);
    check("3c_pchk_other", n_pchko - s_pchko, 0);
    check("3c_dv", n_dv - s_dv, 1);
    check("3c_latency", dv_cyc - t0, 176);
    check("3c_pf", n_pf - s_pf, 0);
    check("3c_byte", rx_byte, 8'h3C);
    snap();
    send(16, 8'h3C, 1, 1, 1, -1, -1);
    check("perr_pf", n_pf - s_pf, 1);
    check("perr_dv", n_dv - s_dv, 0);
    check("perr_se", n_se - s_se, 0);
    snap();
    send(32, 8'h5A, 0, 0, 0, -1, -1);
    check("stop0_se", n_se - s_se, 1);
    check("stop0_dv", n_dv - s_dv, 0);
    check("stop0_pf", n_pf - s_pf, 0);
    check("stop0_byte", rx_byte, 8'h5A);
    // 3-cycle low glitch: sampled_bit is 0 from the bad stop bit, vote must raise it
    snap();
    Prescale = 6'd8;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      RX_IN = k < 3 ? 1'b0 : 1'b1;
      @(negedge CLK);
      ek[k] = edge_cnt;
      sk[k] = sampled_bit;
    end
    check("gl_sampled_before", sk[5], 0);
    check("gl_edge6", ek[6], 6);
    check("gl_sampled6", sk[6], 1);
    check("gl_edge_abort", ek[7], 0);
    check("gl_edge_idle", ek[9], 0);
    check("gl_deser", n_deser - s_deser, 0);
    check("gl_results", (n_dv - s_dv) + (n_se - s_se) + (n_pf - s_pf), 0);
    snap();
    send(8, 8'hA5, 0, 1, 0, 4, -1);
    check("flip_byte", rx_byte, 8'hA5);
    check("flip_dv", n_dv - s_dv, 1);
    snap();
    send(8, 8'h69, 0, 1, 0, -1, 5);
    #1;
    check("mid_rst_edge", edge_cnt, 0);
    check("mid_rst_bit", bit_cnt, 0);
    check("mid_rst_sampled", sampled_bit, 1);
    check("mid_rst_strobes", {deser_en, par_chk_en, data_valid, stp_err, par_fail}, 0);
    repeat (20) @(posedge CLK);
    #1;
    RST = 1'b1;
    check("mid_rst_no_result", (n_dv - s_dv) + (n_se - s_se) + (n_pf - s_pf), 0);
    repeat (2) @(posedge CLK);
    snap();
    send(8, 8'hC3, 1, 1, 0, -1, -1);
    check("post_rst_dv", n_dv - s_dv, 1);
    check("post_rst_byte", rx_byte, 8'hC3);
    check("post_rst_latency", dv_cyc - t0, 88);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
